// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master: IDLE/SETUP/ACCESS sequencing, all outputs registered.
// Define APB_TIMEOUT_EN to add an ACCESS watchdog that force-completes with err = 1 after TIMEOUT_CYCLES.
module apb_master_arbiter #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic [1:0]        PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t            state;
    logic              grant;
    logic              rr_ptr;
    logic              next_grant;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              timeout;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        next_grant = rr_ptr;
        if (req0_valid && !req1_valid)
            next_grant = 1'b0;
        else if (req1_valid && !req0_valid)
            next_grant = 1'b1;
        sel_write = next_grant ? req1_write : req0_write;
        sel_addr  = next_grant ? req1_addr  : req0_addr;
        sel_wdata = next_grant ? req1_wdata : req0_wdata;
    end

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive ACCESS cycle without PREADY.
    assign timeout = !PREADY && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog the parameter only documents the interface.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // NOTE: every register here is state, so only non-blocking assignments appear in this block.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state      <= S_IDLE;
            grant      <= 1'b0;
            rr_ptr     <= 1'b0;
            PSEL       <= 2'b00;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            req0_ready <= 1'b0;
            req0_done  <= 1'b0;
            req0_rdata <= '0;
            req0_err   <= 1'b0;
            req1_ready <= 1'b0;
            req1_done  <= 1'b0;
            req1_rdata <= '0;
            req1_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        grant  <= next_grant;
                        PWRITE <= sel_write;
                        PADDR  <= sel_addr;
                        PWDATA <= sel_wdata;
                        PSEL   <= sel_addr[ADDR_W-1] ? 2'b10 : 2'b01;
                        if (next_grant)
                            req1_ready <= 1'b1;
                        else
                            req0_ready <= 1'b1;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_ACCESS: begin
                    if (PREADY || timeout) begin
                        PSEL    <= 2'b00;
                        PENABLE <= 1'b0;
                        rr_ptr  <= ~grant;
                        state   <= S_IDLE;
                        if (grant) begin
                            req1_done <= 1'b1;
                            req1_err  <= PREADY ? PSLVERR : 1'b1;
                            if (!PREADY)
                                req1_rdata <= '0;
                            else if (!PWRITE)
                                req1_rdata <= PRDATA;
                        end else begin
                            req0_done <= 1'b1;
                            req0_err  <= PREADY ? PSLVERR : 1'b1;
                            if (!PREADY)
                                req0_rdata <= '0;
                            else if (!PWRITE)
                                req0_rdata <= PRDATA;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter; the slave side is driven by hand.
// Define APB_TIMEOUT_EN for both bench and RTL to exercise the watchdog build.
module tb_apb_master_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req_valid [2];
    logic        req_write [2];
    logic [4:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        ready     [2];
    logic        done      [2];
    logic [31:0] rdata     [2];
    logic        err       [2];
    logic [1:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_checks = 0;
    int n_errors = 0;

    apb_master_arbiter dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req0_valid (req_valid[0]),
        .req0_write (req_write[0]),
        .req0_addr  (req_addr[0]),
        .req0_wdata (req_wdata[0]),
        .req0_ready (ready[0]),
        .req0_done  (done[0]),
        .req0_rdata (rdata[0]),
        .req0_err   (err[0]),
        .req1_valid (req_valid[1]),
        .req1_write (req_write[1]),
        .req1_addr  (req_addr[1]),
        .req1_wdata (req_wdata[1]),
        .req1_ready (ready[1]),
        .req1_done  (done[1]),
        .req1_rdata (rdata[1]),
        .req1_err   (err[1]),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESETn = 1'b1;
        for (int i = 0; i < 2; i++) req_valid[i] = 1'b0;
        PREADY = 1'b0;
        step();
        step();
        PRESETn = 1'b0;
    endtask

    // One complete transfer with 'waits' PREADY=0 cycles before the ready cycle.
    task automatic xfer(input int idx, input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd, input logic slverr,
                        input logic [31:0] exp_rdata);
        int    acc;
        bit    seen;
        string t;
        t = $sformatf("xfer%0d_%0h", idx, addr);
        req_valid[idx] = 1'b1;
        req_write[idx] = wr;
        req_addr[idx]  = addr;
        req_wdata[idx] = wd;
        PREADY  = 1'b0;
        PRDATA  = rd;
        PSLVERR = slverr;
        step();
        check({t, "_ready"}, 32'(ready[idx]), 1);
        check({t, "_other_ready"}, 32'(ready[1-idx]), 0);
        check({t, "_setup_psel"}, 32'(PSEL), addr[4] ? 32'h2 : 32'h1);
        check({t, "_setup_penable"}, 32'(PENABLE), 0);
        req_valid[idx] = 1'b0;
        acc  = 0;
        seen = 1'b0;
        for (int g = 0; g < 40 && !seen; g++) begin
            step();
            if (done[idx]) begin
                seen = 1'b1;
            end else if (PENABLE) begin
                acc++;
                if (acc == 1) begin
                    check({t, "_paddr"}, 32'(PADDR), 32'(addr));
                    check({t, "_pwrite"}, 32'(PWRITE), 32'(wr));
                    check({t, "_pwdata"}, PWDATA, wd);
                end
                if (acc == waits + 1) PREADY = 1'b1;
            end
        end
        PREADY = 1'b0;
        check({t, "_done"}, 32'(seen), 1);
        check({t, "_access_cycles"}, acc, waits + 1);
        check({t, "_other_done"}, 32'(done[1-idx]), 0);
        check({t, "_err"}, 32'(err[idx]), 32'(slverr));
        check({t, "_rdata"}, rdata[idx], exp_rdata);
        check({t, "_idle_psel"}, 32'(PSEL), 0);
        check({t, "_idle_penable"}, 32'(PENABLE), 0);
        step();
        check({t, "_done_pulse"}, 32'(done[idx]), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int acc;
        bit seen;

        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end
        PRDATA  = '0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;

        // Reset held with a pending request: no grant until reset drops.
        PRESETn      = 1'b1;
        req_valid[0] = 1'b1;
        step();
        check("rst_ready0", 32'(ready[0]), 0);
        check("rst_psel", 32'(PSEL), 0);
        check("rst_penable", 32'(PENABLE), 0);
        check("rst_done0", 32'(done[0]), 0);
        check("rst_rdata0", rdata[0], 0);
        check("rst_err1", 32'(err[1]), 0);
        step();
        check("rst_ready0_2nd", 32'(ready[0]), 0);
        check("rst_paddr", 32'(PADDR), 0);
        PRESETn = 1'b0;
        step();
        check("rst_first_grant", 32'(ready[0]), 1);
        req_valid[0] = 1'b0;
        PREADY = 1'b1;
        step();
        step();
        step();
        do_reset();

        // Write, zero wait states.
        xfer(0, 1'b1, 5'h01, 32'hABCD_1234, 0, 32'h0, 1'b0, 32'h0);
        // Read from UART with three wait states.
        xfer(1, 1'b0, 5'h12, 32'h0, 3, 32'h0000_0AAA, 1'b0, 32'h0000_0AAA);
        // Write on req1 leaves its read data untouched.
        xfer(1, 1'b1, 5'h13, 32'h0000_1234, 1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0AAA);
        // Slave error on a read.
        xfer(0, 1'b0, 5'h03, 32'h0, 0, 32'h0000_0055, 1'b1, 32'h0000_0055);
        check("hold_rdata1", rdata[1], 32'h0000_0AAA);

        // Reset during ACCESS drops the transfer.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 5'h02;
        PREADY = 1'b0;
        step();
        req_valid[0] = 1'b0;
        step();
        check("midrst_in_access", 32'(PENABLE), 1);
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        step();
        check("midrst_psel", 32'(PSEL), 0);
        check("midrst_penable", 32'(PENABLE), 0);
        check("midrst_done0", 32'(done[0]), 0);
        PRESETn = 1'b0;
        PREADY  = 1'b0;
        step();
        check("midrst_done0_after", 32'(done[0]), 0);
        check("midrst_err0", 32'(err[0]), 0);

        // Both requesters busy: strict alternation from a fresh pointer.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b1;
            req_write[i] = 1'b1;
        end
        req_addr[0] = 5'h01;
        req_addr[1] = 5'h11;
        PREADY = 1'b1;
        for (int t = 0; t < 4; t++) begin
            found = -1;
            for (int g = 0; g < 10 && found < 0; g++) begin
                step();
                if (ready[0]) found = 0;
                else if (ready[1]) found = 1;
            end
            check($sformatf("arb_grant%0d", t), found, t % 2);
        end
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        step();
        step();
        step();

        // Lone requester 1 wins despite the pointer favouring 0.
        do_reset();
        req_valid[1] = 1'b1;
        step();
        check("single_ready1", 32'(ready[1]), 1);
        check("single_ready0", 32'(ready[0]), 0);
        req_valid[1] = 1'b0;
        PREADY = 1'b1;
        step();
        step();
        step();
        PREADY = 1'b0;

        // Slave never answers.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 5'h04;
        PRDATA = 32'h0000_0077;
        step();
        req_valid[0] = 1'b0;
`ifdef APB_TIMEOUT_EN
        acc  = 0;
        seen = 1'b0;
        for (int g = 0; g < 40 && !seen; g++) begin
            step();
            if (done[0]) seen = 1'b1;
            else if (PENABLE) acc++;
        end
        check("tmo_done", 32'(seen), 1);
        check("tmo_access_cycles", acc, 16);
        check("tmo_err", 32'(err[0]), 1);
        check("tmo_rdata", rdata[0], 0);
        check("tmo_psel", 32'(PSEL), 0);
`else
        seen = 1'b0;
        for (int g = 0; g < 100; g++) begin
            step();
            if (done[0]) seen = 1'b1;
        end
        check("notmo_no_done", 32'(seen), 0);
        check("notmo_penable", 32'(PENABLE), 1);
        check("notmo_psel", 32'(PSEL), 1);
        PREADY = 1'b1;
        step();
        check("notmo_late_done", 32'(done[0]), 1);
        check("notmo_late_rdata", rdata[0], 32'h0000_0077);
        PREADY = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
